mct_scheduler: RTL and testbench
================================

// Module: mct_scheduler
// PURPOSE
// - Owns the 10-pulse timing ring (TP1..TP10); one full ring pass = one memory cycle time (MCT).
// - Decides which requester owns each MCT: counter increment (cinc), interrupt, instruction or idle.
// - Adds run/halt control.
// - Sits between the control-pulse matrix and the requesters; all downstream logic qualifies on tp/owner.
// PARAMETERS
// - NUM_TP     10  pulses per MCT; phase counts 0..NUM_TP-1
// - MAX_STEAL  2   max consecutive cinc MCTs while an instruction is in progress
// - MCT_CNT_W  16  width of free-running MCT counter
// PORTS
// - clk         in   1          system clock; all state advances on the falling edge
// - reset       in   1          synchronous, active-high
// - run         in   1          1 = sequence MCTs, 0 = halt at next MCT boundary
// - cinc_req    in   1          counter-increment request (level)
// - cinc_gnt    out  1          1-clk pulse: cinc owns the current MCT
// - int_req     in   1          interrupt request (level)
// - int_en      in   1          interrupt enable
// - int_gnt     out  1          1-clk pulse: interrupt owns the current MCT
// - instr_req   in   1          new instruction request (level)
// - instr_mcts  in   2          MCT length of requested instruction, 1..3 (0 treated as 1)
// - instr_gnt   out  1          1-clk pulse: instruction accepted, first MCT starting
// - instr_done  out  1          1-clk pulse in last phase of final instruction MCT
// - tp          out  NUM_TP     one-hot timing pulses; tp[k] high during phase k
// - owner       out  2          current MCT owner (package encoding)
// - mct_cnt     out  MCT_CNT_W  completed MCTs, wraps to 0
// - step        in   1          single-step strobe (only with SEQ_STEP_EN)
// BEHAVIOUR
// - Reset: phase=0, running=0, tp=0, owner=IDLE, remaining=0, steal=0, mct_cnt=0, all gnt/done=0.
//   In-progress instruction is abandoned.
// - Running: phase increments by 1 per clk and wraps NUM_TP-1 -> 0; tp = onehot(phase); tp=0 when halted.
// - Arbitration at phase NUM_TP-1, for the next MCT, in priority order:
//   1. cinc_req, unless remaining>0 and steal==MAX_STEAL.
//   2. Continue instruction if remaining>0; remaining--.
//   3. int_req && int_en (only when remaining==0).
//   4. instr_req; remaining = max(instr_mcts,1)-1.
//   5. Otherwise IDLE.
// - owner updates on the wrap to phase 0; the matching *_gnt pulses for exactly the phase-0 clk.
//   Continuation MCTs assert no gnt.
// - steal counter:
//   - cinc MCT with remaining>0: steal++.
//   - Any instruction MCT: steal=0.
//   - remaining==0: steal=0.
// - instr_done pulses at phase NUM_TP-1 when owner==INSTR and remaining==0.
// - mct_cnt++ on every wrap NUM_TP-1 -> 0, including IDLE MCTs.
// - Halt/resume:
//   - run sampled at phase NUM_TP-1. If 0: MCT completes, then running=0, phase=0, tp=0, owner=IDLE.
//   - While halted, remaining and steal are held.
//   - run=1 while halted: arbitration is performed that clk; the next clk enters phase 0 with gnt.
// - Simultaneous requests resolve strictly by the priority above.
// - Requesters hold req until gnt and drop it the clk after; a held req is re-granted at the next boundary.
// CONFIGURATION
// - SEQ_STEP_EN defined: step port exists. While halted, a step pulse runs exactly one MCT
//   (arbitrated as on resume), then the block re-halts regardless of run.
// - SEQ_STEP_EN undefined: no step port; only run controls halting.
// STRUCTURE
// - Package seq_pkg:
//   - owner_t = OWN_IDLE 0, OWN_INSTR 1, OWN_CINC 2, OWN_INT 3.
//   - Default constants NUM_TP and MAX_STEAL.
// - Sub-module tp_ring: phase counter, wrap strobe and one-hot tp decode with a run gate.
// - Arbitration, steal logic and grants stay in mct_scheduler.
// TESTING
// 1. reset=1 mid-MCT (phase 4, remaining 2) -> next clk tp=0, owner=0, mct_cnt=0; run=1 -> tp[0] after 1 clk.
// 2. run=1, no reqs, 30 clks -> tp walks one-hot 0..9 three times, owner=IDLE, mct_cnt=3.
// 3. instr_req with instr_mcts=3 -> instr_gnt once, owner=INSTR for 3 MCTs, instr_done at phase 9 of MCT 3.
// 4. 3-MCT instruction with cinc_req held high -> sequence INSTR,CINC,CINC,INSTR,CINC,CINC,INSTR.
// 5. int_req+int_en+instr_req together at an idle boundary -> int_gnt, then instr_gnt next MCT;
//    int_en=0 -> instr only.
// 6. run dropped at phase 5 -> MCT completes, tp=0 held.
//    With SEQ_STEP_EN, one step pulse -> exactly 10 tp pulses, then halt.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and default constants for the MCT scheduler and its timing ring.
// Owner encoding is visible on the scheduler's owner port.
package seq_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_CINC  = 2'd2,
        OWN_INT   = 2'd3
    } owner_t;

    localparam int NUM_TP_DEFAULT    = 10;
    localparam int MAX_STEAL_DEFAULT = 2;
    localparam int MCT_CNT_W_DEFAULT = 16;

    // MCTs still owed after the first one; a length of 0 behaves as 1.
    function automatic logic [1:0] first_remaining(input logic [1:0] mcts);
        return (mcts == 2'd0) ? 2'd0 : mcts - 2'd1;
    endfunction

endpackage

// File: rtl/tp_ring.sv
// Timing-pulse ring: phase counter, wrap strobe and run-gated one-hot tp decode.
// The phase is forced to 0 whenever the ring is not enabled.
module tp_ring
    import seq_pkg::*;
#(
    parameter  int NUM_TP = NUM_TP_DEFAULT,
    localparam int PH_W   = $clog2(NUM_TP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [PH_W-1:0]   phase,
    output logic              wrap,
    output logic [NUM_TP-1:0] tp
);

    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;

    assign wrap  = en && (phase_q == PH_W'(NUM_TP - 1));
    assign phase = phase_q;

    always_comb begin
        phase_d = phase_q + PH_W'(1);
        if (!en || wrap) begin
            phase_d = '0;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    for (genvar gi = 0; gi < NUM_TP; gi++) begin : g_tp
        assign tp[gi] = en && (phase_q == PH_W'(gi));
    end

endmodule

// File: rtl/mct_scheduler.sv
// MCT scheduler: arbitrates ownership of each memory cycle between cinc, interrupt and
// instructions, with run/halt control. Optional single-step port under SEQ_STEP_EN.
module mct_scheduler
    import seq_pkg::*;
#(
    parameter int NUM_TP    = NUM_TP_DEFAULT,
    parameter int MAX_STEAL = MAX_STEAL_DEFAULT,
    parameter int MCT_CNT_W = MCT_CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
`ifdef SEQ_STEP_EN
    input  logic                 step,
`endif
    input  logic                 cinc_req,
    output logic                 cinc_gnt,
    input  logic                 int_req,
    input  logic                 int_en,
    output logic                 int_gnt,
    input  logic                 instr_req,
    input  logic [1:0]           instr_mcts,
    output logic                 instr_gnt,
    output logic                 instr_done,
    output logic [NUM_TP-1:0]    tp,
    output owner_t               owner,
    output logic [MCT_CNT_W-1:0] mct_cnt
);

    localparam int PH_W = $clog2(NUM_TP);
    localparam int ST_W = $clog2(MAX_STEAL + 1);

    logic step_w;
`ifdef SEQ_STEP_EN
    assign step_w = step;
`else
    assign step_w = 1'b0;
`endif

    logic                 running_q, running_d;
    logic                 step_mode_q, step_mode_d;
    owner_t               owner_q, owner_d;
    logic [1:0]           remaining_q, remaining_d;
    logic [ST_W-1:0]      steal_q, steal_d;
    logic [MCT_CNT_W-1:0] mct_cnt_q, mct_cnt_d;
    logic                 cinc_gnt_q, cinc_gnt_d;
    logic                 int_gnt_q, int_gnt_d;
    logic                 instr_gnt_q, instr_gnt_d;
    logic                 instr_done_q, instr_done_d;

    logic [PH_W-1:0] phase;
    logic            wrap;
    owner_t          next_owner;
    logic            instr_starved;
    logic            start;
    logic            keep;

    tp_ring #(.NUM_TP(NUM_TP)) u_ring (
        .clk   (clk),
        .reset (reset),
        .en    (running_q),
        .phase (phase),
        .wrap  (wrap),
        .tp    (tp)
    );

    always_comb begin
        running_d    = running_q;
        step_mode_d  = step_mode_q;
        owner_d      = owner_q;
        remaining_d  = remaining_q;
        steal_d      = steal_q;
        mct_cnt_d    = mct_cnt_q;
        cinc_gnt_d   = 1'b0;
        int_gnt_d    = 1'b0;
        instr_gnt_d  = 1'b0;

        // An instruction in flight reclaims the memory once cinc has stolen MAX_STEAL MCTs.
        instr_starved = (remaining_q != 2'd0) && (steal_q == ST_W'(MAX_STEAL));
        if (cinc_req && !instr_starved)  next_owner = OWN_CINC;
        else if (remaining_q != 2'd0)    next_owner = OWN_INSTR;
        else if (int_req && int_en)      next_owner = OWN_INT;
        else if (instr_req)              next_owner = OWN_INSTR;
        else                             next_owner = OWN_IDLE;

        start = !running_q && (run || step_w);
        keep  = run && !step_mode_q;

        instr_done_d = running_q && (phase == PH_W'(NUM_TP - 2))
                       && (owner_q == OWN_INSTR) && (remaining_q == 2'd0);

        if (wrap) begin
            mct_cnt_d = mct_cnt_q + MCT_CNT_W'(1);
            if (!keep) begin
                running_d   = 1'b0;
                step_mode_d = 1'b0;
                owner_d     = OWN_IDLE;
            end
        end

        if ((wrap && keep) || start) begin
            running_d = 1'b1;
            if (start) begin
                step_mode_d = step_w;
            end
            owner_d = next_owner;
            case (next_owner)
                OWN_CINC: begin
                    cinc_gnt_d = 1'b1;
                    steal_d    = (remaining_q != 2'd0) ? steal_q + ST_W'(1) : '0;
                end
                OWN_INSTR: begin
                    steal_d = '0;
                    if (remaining_q != 2'd0) begin
                        remaining_d = remaining_q - 2'd1;
                    end else begin
                        remaining_d = first_remaining(instr_mcts);
                        instr_gnt_d = 1'b1;
                    end
                end
                OWN_INT: begin
                    int_gnt_d = 1'b1;
                    steal_d   = '0;
                end
                default: steal_d = '0;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            running_q    <= 1'b0;
            step_mode_q  <= 1'b0;
            owner_q      <= OWN_IDLE;
            remaining_q  <= 2'd0;
            steal_q      <= '0;
            mct_cnt_q    <= '0;
            cinc_gnt_q   <= 1'b0;
            int_gnt_q    <= 1'b0;
            instr_gnt_q  <= 1'b0;
            instr_done_q <= 1'b0;
        end else begin
            running_q    <= running_d;
            step_mode_q  <= step_mode_d;
            owner_q      <= owner_d;
            remaining_q  <= remaining_d;
            steal_q      <= steal_d;
            mct_cnt_q    <= mct_cnt_d;
            cinc_gnt_q   <= cinc_gnt_d;
            int_gnt_q    <= int_gnt_d;
            instr_gnt_q  <= instr_gnt_d;
            instr_done_q <= instr_done_d;
        end
    end

    assign cinc_gnt   = cinc_gnt_q;
    assign int_gnt    = int_gnt_q;
    assign instr_gnt  = instr_gnt_q;
    assign instr_done = instr_done_q;
    assign owner      = owner_q;
    assign mct_cnt    = mct_cnt_q;

endmodule

// File: tb/tb_mct_scheduler.sv
// Directed bench for mct_scheduler; the DUT advances on the falling edge, so the bench
// samples and drives just after each rising edge. Step scenario runs when SEQ_STEP_EN is set.
module tb_mct_scheduler;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        cinc_req = 1'b0;
    logic        int_req = 1'b0;
    logic        int_en = 1'b0;
    logic        instr_req = 1'b0;
    logic [1:0]  instr_mcts = 2'd0;
`ifdef SEQ_STEP_EN
    logic        step = 1'b0;
`endif
    logic        cinc_gnt, int_gnt, instr_gnt, instr_done;
    logic [9:0]  tp;
    owner_t      owner;
    logic [15:0] mct_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mct_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
`ifdef SEQ_STEP_EN
        .step       (step),
`endif
        .cinc_req   (cinc_req),
        .cinc_gnt   (cinc_gnt),
        .int_req    (int_req),
        .int_en     (int_en),
        .int_gnt    (int_gnt),
        .instr_req  (instr_req),
        .instr_mcts (instr_mcts),
        .instr_gnt  (instr_gnt),
        .instr_done (instr_done),
        .tp         (tp),
        .owner      (owner),
        .mct_cnt    (mct_cnt)
    );

    task automatic tick();
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b0;
        repeat (3) tick();
        reset = 1'b0; run = 1'b1; instr_req = 1'b1; instr_mcts = 2'd3;
        tick();
        checks++;
        if (tp !== 10'b0000000001 || instr_gnt !== 1'b1 || owner !== OWN_INSTR) begin
            errors++;
            $display("FAIL reset_first_mct: tp=%b gnt=%b owner=%0d, want tp=0000000001 gnt=1 owner=1", tp, instr_gnt, owner);
        end
        instr_req = 1'b0;
        repeat (4) tick();
        checks++;
        if (tp !== 10'b0000010000) begin
            errors++;
            $display("FAIL reset_phase4: tp=%b want 0000010000", tp);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (tp !== 10'b0) begin
            errors++;
            $display("FAIL reset_tp: tp=%b want 0", tp);
        end
        checks++;
        if (owner !== OWN_IDLE) begin
            errors++;
            $display("FAIL reset_owner: owner=%0d want 0", owner);
        end
        checks++;
        if (mct_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mct_cnt: mct_cnt=%0d want 0", mct_cnt);
        end
        checks++;
        if ({cinc_gnt, int_gnt, instr_gnt, instr_done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_pulses: gnt/done=%b want 0000", {cinc_gnt, int_gnt, instr_gnt, instr_done});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (tp !== 10'b0000000001 || owner !== OWN_IDLE) begin
            errors++;
            $display("FAIL reset_resume: tp=%b owner=%0d want tp=0000000001 owner=0", tp, owner);
        end
        $display("test_reset: resumed idle after reset");
    endtask

    task automatic test_idle_ring();
        logic [9:0] exp_tp;
        for (int i = 0; i < 30; i++) begin
            exp_tp = 10'd1 << (i % 10);
            checks++;
            if (tp !== exp_tp || owner !== OWN_IDLE) begin
                errors++;
                $display("FAIL idle_ring[%0d]: tp=%b owner=%0d want tp=%b owner=0", i, tp, owner, exp_tp);
            end
            tick();
        end
        checks++;
        if (mct_cnt !== 16'd3) begin
            errors++;
            $display("FAIL idle_mct_cnt: mct_cnt=%0d want 3", mct_cnt);
        end
        $display("test_idle_ring: 3 idle MCTs");
    endtask

    task automatic test_instr();
        owner_t got [4];
        owner_t exp_own [4] = '{OWN_INSTR, OWN_INSTR, OWN_INSTR, OWN_IDLE};
        int nb = 0, gnt_cnt = 0, done_cnt = 0, done_c = -1;
        instr_req = 1'b1; instr_mcts = 2'd3;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (instr_gnt) begin gnt_cnt++; instr_req = 1'b0; end
            if (instr_done) begin done_cnt++; done_c = c; end
            if (tp[0] && nb < 4) begin got[nb] = owner; nb++; end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= nb || got[k] !== exp_own[k]) begin
                errors++;
                $display("FAIL instr_owner[%0d]: owner=%0d want %0d (boundaries seen %0d)", k, got[k], exp_own[k], nb);
            end
        end
        checks++;
        if (gnt_cnt != 1 || done_cnt != 1 || done_c != 38) begin
            errors++;
            $display("FAIL instr_pulses: gnt=%0d done=%0d at %0d want gnt=1 done=1 at 38", gnt_cnt, done_cnt, done_c);
        end
        checks++;
        if (mct_cnt !== 16'd7) begin
            errors++;
            $display("FAIL instr_mct_cnt: mct_cnt=%0d want 7", mct_cnt);
        end
        $display("test_instr: 3-MCT instruction");
    endtask

    task automatic test_cinc_steal();
        owner_t got [7];
        owner_t exp_own [7] = '{OWN_INSTR, OWN_CINC, OWN_CINC, OWN_INSTR, OWN_CINC, OWN_CINC, OWN_INSTR};
        int nb = 0, igc = 0, cgc = 0, done_cnt = 0, done_c = -1;
        instr_req = 1'b1; instr_mcts = 2'd3;
        for (int c = 0; c < 79; c++) begin
            tick();
            if (instr_gnt) begin igc++; instr_req = 1'b0; cinc_req = 1'b1; end
            if (cinc_gnt) cgc++;
            if (instr_done) begin done_cnt++; done_c = c; end
            if (tp[0] && nb < 7) begin got[nb] = owner; nb++; end
        end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (k >= nb || got[k] !== exp_own[k]) begin
                errors++;
                $display("FAIL steal_owner[%0d]: owner=%0d want %0d", k, got[k], exp_own[k]);
            end
        end
        checks++;
        if (igc != 1 || cgc != 4 || done_cnt != 1 || done_c != 78) begin
            errors++;
            $display("FAIL steal_pulses: instr_gnt=%0d cinc_gnt=%0d done=%0d at %0d want 1 4 1 at 78", igc, cgc, done_cnt, done_c);
        end
        cinc_req = 1'b0;
        tick();
        checks++;
        if (owner !== OWN_IDLE || tp !== 10'b1 || cinc_gnt !== 1'b0) begin
            errors++;
            $display("FAIL steal_end: owner=%0d tp=%b cinc_gnt=%b want 0 0000000001 0", owner, tp, cinc_gnt);
        end
        $display("test_cinc_steal: cinc interleaved with instruction");
    endtask

    task automatic test_int_priority();
        owner_t     got_own [3];
        logic [2:0] got_g [3];
        owner_t     exp_a [3] = '{OWN_INT, OWN_INSTR, OWN_IDLE};
        logic [2:0] exp_ga [3] = '{3'b100, 3'b010, 3'b000};
        owner_t     exp_b [2] = '{OWN_INSTR, OWN_IDLE};
        logic [2:0] exp_gb [2] = '{3'b010, 3'b000};
        int nb = 0, done_c = -1;
        int_req = 1'b1; int_en = 1'b1; instr_req = 1'b1; instr_mcts = 2'd1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (tp[0] && nb < 3) begin got_own[nb] = owner; got_g[nb] = {int_gnt, instr_gnt, cinc_gnt}; nb++; end
            if (int_gnt) int_req = 1'b0;
            if (instr_gnt) instr_req = 1'b0;
            if (instr_done) done_c = c;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= nb || got_own[k] !== exp_a[k] || got_g[k] !== exp_ga[k]) begin
                errors++;
                $display("FAIL int_en1[%0d]: owner=%0d gnt(int,instr,cinc)=%b want %0d %b", k, got_own[k], got_g[k], exp_a[k], exp_ga[k]);
            end
        end
        checks++;
        if (done_c != 28) begin
            errors++;
            $display("FAIL int_en1_done: done at %0d want 28", done_c);
        end
        nb = 0; done_c = -1;
        int_req = 1'b1; int_en = 1'b0; instr_req = 1'b1; instr_mcts = 2'd0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (tp[0] && nb < 2) begin got_own[nb] = owner; got_g[nb] = {int_gnt, instr_gnt, cinc_gnt}; nb++; end
            if (instr_gnt) instr_req = 1'b0;
            if (instr_done) done_c = c;
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (k >= nb || got_own[k] !== exp_b[k] || got_g[k] !== exp_gb[k]) begin
                errors++;
                $display("FAIL int_en0[%0d]: owner=%0d gnt(int,instr,cinc)=%b want %0d %b", k, got_own[k], got_g[k], exp_b[k], exp_gb[k]);
            end
        end
        checks++;
        if (done_c != 18) begin
            errors++;
            $display("FAIL int_en0_done: done at %0d want 18 (mcts=0 runs one MCT)", done_c);
        end
        int_req = 1'b0;
        $display("test_int_priority: int before instr, masked int ignored");
    endtask

    task automatic test_halt();
        logic [9:0] exp_tp;
        int done_c = -1;
        instr_req = 1'b1; instr_mcts = 2'd2;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 9) begin
                checks++;
                if (instr_gnt !== 1'b1 || owner !== OWN_INSTR) begin
                    errors++;
                    $display("FAIL halt_gnt: gnt=%b owner=%0d want 1 1", instr_gnt, owner);
                end
            end
            if (instr_gnt) instr_req = 1'b0;
            if (c >= 15 && c <= 18) begin
                exp_tp = 10'd1 << (c - 9);
                checks++;
                if (tp !== exp_tp) begin
                    errors++;
                    $display("FAIL halt_finish[%0d]: tp=%b want %b", c, tp, exp_tp);
                end
            end
            if (c >= 19 && c <= 28) begin
                checks++;
                if (tp !== 10'b0 || owner !== OWN_IDLE || {cinc_gnt, int_gnt, instr_gnt} !== 3'b0) begin
                    errors++;
                    $display("FAIL halt_held[%0d]: tp=%b owner=%0d want tp=0 owner=0 no gnt", c, tp, owner);
                end
            end
            if (c == 29) begin
                checks++;
                if (tp !== 10'b1 || owner !== OWN_INSTR || instr_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL halt_resume: tp=%b owner=%0d gnt=%b want 0000000001 1 0", tp, owner, instr_gnt);
                end
            end
            if (instr_done) done_c = c;
            if (c == 14) run = 1'b0;
            if (c == 28) run = 1'b1;
        end
        checks++;
        if (done_c != 38) begin
            errors++;
            $display("FAIL halt_done: done at %0d want 38", done_c);
        end
        $display("test_halt: halt mid-instruction and resume");
    endtask

`ifdef SEQ_STEP_EN
    task automatic test_step();
        int pulses = 0;
        run = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c >= 12 && tp !== 10'b0) pulses++;
            if (c == 13) begin
                checks++;
                if (tp !== 10'b1 || owner !== OWN_IDLE) begin
                    errors++;
                    $display("FAIL step_start: tp=%b owner=%0d want 0000000001 0", tp, owner);
                end
            end
            step = (c == 12);
        end
        checks++;
        if (pulses != 10 || tp !== 10'b0) begin
            errors++;
            $display("FAIL step_pulses: pulses=%0d tp=%b want 10 and tp=0", pulses, tp);
        end
        $display("test_step: one stepped MCT");
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_idle_ring();
        test_instr();
        test_cinc_steal();
        test_int_priority();
        test_halt();
`ifdef SEQ_STEP_EN
        test_step();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
